// File: rtl/writeback_buf.sv
// Writeback queue: buffers dual-channel register-file writes, extracts load data
// and forwards the youngest queued value. Define WB_LOAD_SEXT_EN to honour in_sext.
module writeback_buf #(
  parameter int DATA_W = 32,  // load extraction assumes DATA_W >= 32
  parameter int TGT_W  = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_we1,
  input  logic                       in_we2,
  input  logic [TGT_W-1:0]           in_tgt1,
  input  logic [TGT_W-1:0]           in_tgt2,
  input  logic [DATA_W-1:0]          in_res1,
  input  logic [DATA_W-1:0]          in_res2,
  input  logic                       in_is_load,
  input  logic [1:0]                 in_size,
  input  logic [1:0]                 in_addr,
  input  logic [DATA_W-1:0]          in_mem,
  input  logic                       in_sext,
  input  logic                       flush,
  input  logic                       rf_ready,
  output logic                       rf_we1,
  output logic                       rf_we2,
  output logic [TGT_W-1:0]           rf_tgt1,
  output logic [TGT_W-1:0]           rf_tgt2,
  output logic [DATA_W-1:0]          rf_data1,
  output logic [DATA_W-1:0]          rf_data2,
  input  logic [TGT_W-1:0]           fwd_tgt,
  output logic                       fwd_hit,
  output logic [DATA_W-1:0]          fwd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic              v1;
    logic              v2;
    logic [TGT_W-1:0]  tgt1;
    logic [TGT_W-1:0]  tgt2;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            in_v1, in_v2;
  logic            accept, store, pop, not_empty;
  logic            sext_en;
  logic [7:0]      lane8;
  logic [15:0]     lane16;
  logic [DATA_W-1:0] load_data;
  entry_t          new_entry;
  entry_t          head;

`ifdef WB_LOAD_SEXT_EN
  assign sext_en = in_sext;
`else
  logic unused_sext;
  assign unused_sext = in_sext;
  assign sext_en     = 1'b0;
`endif

  // Lane selection for sub-word loads.
  always_comb begin
    lane8     = '0;
    lane16    = '0;
    load_data = '0;
    case (in_addr)
      2'b00:   lane8 = in_mem[7:0];
      2'b01:   lane8 = in_mem[15:8];
      2'b10:   lane8 = in_mem[23:16];
      default: lane8 = in_mem[31:24];
    endcase
    case (in_addr)
      2'b00:   lane16 = in_mem[15:0];
      2'b01:   lane16 = in_mem[23:8];
      default: lane16 = in_mem[31:16];
    endcase
    case (in_size)
      2'd0:    load_data = in_mem;
      2'd1:    load_data = {{(DATA_W-16){sext_en & lane16[15]}}, lane16};
      2'd2:    load_data = {{(DATA_W-8){sext_en & lane8[7]}}, lane8};
      default: load_data = '0;
    endcase
  end

  assign in_v1     = in_we1 && (in_tgt1 != '0);
  assign in_v2     = in_we2 && (in_tgt2 != '0);
  assign not_empty = (cnt_q != '0);
  // Reset dominates flush so the queue advertises space while held in reset.
  assign in_ready  = rst || (!flush && (cnt_q != CW'(DEPTH)));
  assign accept    = in_valid && in_ready && !flush;
  assign store     = accept && (in_v1 || in_v2);
  assign pop       = rf_ready && not_empty && !flush;

  always_comb begin
    new_entry       = '0;
    new_entry.v1    = in_v1;
    new_entry.v2    = in_v2;
    new_entry.tgt1  = in_tgt1;
    new_entry.tgt2  = in_tgt2;
    new_entry.data1 = in_is_load ? load_data : in_res1;
    new_entry.data2 = in_res2;
  end

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      rd_d  = rd_q + AW'(pop);
      wr_d  = wr_q + AW'(store);
      cnt_d = cnt_q + CW'(store) - CW'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; occupancy (cnt_q) gates
  // every observable use of it, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (store) mem_q[wr_q] <= new_entry;
  end

  assign head     = mem_q[rd_q];
  assign count    = cnt_q;
  assign rf_we1   = not_empty && head.v1;
  assign rf_we2   = not_empty && head.v2;
  assign rf_tgt1  = not_empty ? head.tgt1  : '0;
  assign rf_tgt2  = not_empty ? head.tgt2  : '0;
  assign rf_data1 = not_empty ? head.data1 : '0;
  assign rf_data2 = not_empty ? head.data2 : '0;

  // Walk oldest to youngest so later matches override earlier ones; channel 2
  // is checked after channel 1 so it wins within an entry.
  always_comb begin
    logic [AW-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_q + AW'(i);
      if ((CW'(i) < cnt_q) && (fwd_tgt != '0)) begin
        if (mem_q[idx].v1 && (mem_q[idx].tgt1 == fwd_tgt)) begin
          fwd_hit  = 1'b1;
          fwd_data = mem_q[idx].data1;
        end
        if (mem_q[idx].v2 && (mem_q[idx].tgt2 == fwd_tgt)) begin
          fwd_hit  = 1'b1;
          fwd_data = mem_q[idx].data2;
        end
      end
    end
  end

endmodule

// File: doc/writeback_buf.md
WRITEBACK_BUF -- requirements
Module: writeback_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 32, result width.
REQ-002 SHALL have parameter TGT_W, default 5, register-target width.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries; power of two, >=2.
REQ-004 SHALL have ports, in order:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  writeback request present.
- in_ready  out  1  queue can accept a request.
- in_we1 / in_we2  in  1  channel 1 / 2 write request.
- in_tgt1 / in_tgt2  in  TGT_W  channel 1 / 2 target register.
- in_res1 / in_res2  in  DATA_W  channel 1 / 2 ALU result.
- in_is_load  in  1  channel 1 takes extracted memory data.
- in_size  in  2  load size: 0 word, 1 half, 2 byte, 3 invalid.
- in_addr  in  2  low load-address bits.
- in_mem  in  DATA_W  raw memory word.
- in_sext  in  1  sign-extend load.
- flush  in  1  discard all queued entries.
- rf_ready  in  1  register file accepts the head entry this cycle.
- rf_we1 / rf_we2  out  1  register-file write enables.
- rf_tgt1 / rf_tgt2  out  TGT_W  write targets.
- rf_data1 / rf_data2  out  DATA_W  write data.
- fwd_tgt  in  TGT_W  forwarding lookup register.
- fwd_hit  out  1  a queued entry writes fwd_tgt.
- fwd_data  out  DATA_W  youngest queued value for fwd_tgt.
- count  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-005 SHALL accept a request on a clock edge where in_valid && in_ready && !flush.
REQ-006 SHALL qualify each channel as v = we && (tgt != 0).
REQ-007 SHALL store an accepted request with both v false as nothing: no entry, count unchanged.
REQ-008 SHALL store channel-1 data as the extracted load value when in_is_load, else in_res1.
REQ-009 SHALL extract word as in_mem.
REQ-010 SHALL extract halfword by in_addr: 00 -> [15:0], 01 -> [23:8], 1x -> [31:16].
REQ-011 SHALL extract byte by in_addr: 00 -> [7:0], 01 -> [15:8], 10 -> [23:16], 11 -> [31:24].
REQ-012 SHALL zero-extend extracted data to DATA_W; SHALL produce zero for size 3.
REQ-013 SHALL drive in_ready = (count != DEPTH); a full queue accepts nothing, even with a same-cycle pop.
REQ-014 SHALL present the head entry on the rf_* outputs combinationally from stored state, giving 1-cycle latency from acceptance to visibility.
REQ-015 SHALL drive rf_weN = head channel vN && count != 0; SHALL drive rf_tgt/rf_data as zero when empty.
REQ-016 SHALL pop the head on an edge where rf_ready && count != 0 && !flush; both channels retire together.
REQ-017 SHALL allow a same-edge push and pop with count unchanged and FIFO order preserved.
REQ-018 SHALL wrap read and write pointers modulo DEPTH.
REQ-019 SHALL search all queued entries youngest-first; within one entry channel 2 beats channel 1; the first match sets fwd_hit=1 and fwd_data.
REQ-020 SHALL drive fwd_hit=0 and fwd_data=0 when fwd_tgt == 0 or nothing matches; the incoming request is not searched.
REQ-021 SHALL, on an edge with flush=1, empty the queue, accept nothing and pop nothing.
REQ-022 SHALL hold in_ready=0 while flush=1.

Reset
REQ-023 SHALL, while rst=1, force pointers and count to 0, in_ready=1, all rf_* outputs 0 and fwd_hit/fwd_data 0, regardless of clk.
REQ-024 SHALL, when rst asserts mid-operation, lose all queued entries; no partial write shall issue after reset.

Configuration
REQ-025 SHALL support macro WB_LOAD_SEXT_EN: when defined, in_sext=1 sign-extends byte/half loads from the top extracted bit; when undefined, in_sext is ignored and all loads zero-extend.

Verification
REQ-026 Scenario: rst, then push tgt1=3 res1=0x11 we1=1 with rf_ready=0 -> next cycle rf_we1=1, rf_tgt1=3, rf_data1=0x11, count=1.
REQ-027 Scenario: load byte, in_addr=3, in_mem=0x80FF0000, in_sext=1 -> rf_data1=0xFFFFFF80 with WB_LOAD_SEXT_EN defined, 0x00000080 without.
REQ-028 Scenario: DEPTH=4, rf_ready=0, five valid pushes -> in_ready=0 after the fourth, fifth held; one rf_ready pulse -> in_ready=1, count=3.
REQ-029 Scenario: queue holds tgt 5=0xA (older) and tgt 5=0xB (newer), fwd_tgt=5 -> fwd_hit=1, fwd_data=0xB; fwd_tgt=0 -> fwd_hit=0.
REQ-030 Scenario: count=3 with flush=1 and in_valid=1 -> next cycle count=0, rf_we1=rf_we2=0, input not stored.
REQ-031 Scenario: push with tgt1=0 and we2=0 -> count unchanged, no rf write; rst pulse mid-drain -> count=0 immediately.
